mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit with architectural HI/LO registers.
- Sits directly downstream of the general register file: its A/B operands are the register file's two read ports (RD1/RD2).
- Executes MIPS mult/multu/div/divu/mthi/mtlo with fixed multi-cycle latency and a Busy flag that the control/hazard logic uses to stall later HI/LO accesses.
- HI/LO are read combinationally by the mfhi/mflo datapath.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for multiply operations (legal range 1..15).
- DIV_CYCLES, 10, number of Busy cycles for divide operations (legal range 1..15).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request strobe; sampled on the rising edge.
- Op  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 see Optional Feature.
- A  input  32  operand rs (from register file RD1).
- B  input  32  operand rt (from register file RD2).
- Busy  output  1  high while a multiply/divide is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (Reset=1 at a rising edge) clears HI=0, LO=0, Busy=0 and the cycle counter, and discards any pending result. Reset has priority over everything, including mid-operation.
- Accept rule: Start is accepted only at an edge where Reset=0 and Busy=0. Start while Busy=1 is ignored entirely: no state change, and the operands are not captured.
- States:
  - IDLE (Busy=0).
  - RUN (Busy=1, counter counts down).
- mult/multu/div/divu:
  - At the accepting edge, capture the full result into internal pending registers (hi_n, lo_n), load the counter with N-1 (N = MULT_CYCLES or DIV_CYCLES), and go to RUN. Busy rises after this edge.
  - Busy stays high for exactly N cycles.
  - At the edge where the counter is 0 in RUN, commit HI<=hi_n, LO<=lo_n and return to IDLE. Busy falls and the new HI/LO become visible after that same edge.
  - HI/LO keep their old values throughout RUN.
- mthi/mtlo: on acceptance, HI<=A (mthi) or LO<=A (mtlo) at that edge. Busy stays 0; single-cycle operation.
- Arithmetic rules:
  - mult: signed 32x32, 64-bit product; HI=product[63:32], LO=product[31:0].
  - multu: same as mult, with unsigned operands.
  - div: LO=quotient truncated toward zero, HI=remainder carrying the sign of the dividend A.
  - divu: unsigned quotient and remainder.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0x00000000.
  - Divide by zero (B=0, div or divu): the operation still occupies DIV_CYCLES Busy cycles, and HI/LO are left unchanged at commit.
- Start with an Op that is not enabled performs no operation and leaves Busy low.
- A Start arriving on the same edge that Busy falls is ignored, because Busy=1 is sampled at that edge. A new operation can be accepted at the following edge.
- The block has no PC or trace port.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Op 110 = madd: {HI,LO} <= {HI,LO} + signed(A*B).
  - Op 111 = maddu: {HI,LO} <= {HI,LO} + unsigned(A*B).
  - Both use MULT_CYCLES latency and 64-bit wrap-around addition.
  - The accumulation uses the HI/LO values present at the accepting edge.
- Not defined: Op 110/111 are ignored, as the unenabled-Op rule above.

Test Plan:
1. Reset, then Start mult with A=0xFFFFFFFF, B=0x00000002 -> Busy high for exactly 5 cycles, HI/LO=0 during Busy, then HI=0xFFFFFFFF, LO=0xFFFFFFFE as Busy falls.
2. multu with A=0xFFFFFFFF, B=0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles. Then div with A=0xFFFFFFF9 (-7), B=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. Edge cases:
   - divu A=7, B=0 with HI=0x11, LO=0x22 beforehand -> Busy for 10 cycles, then HI=0x11, LO=0x22.
   - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Start mult at cycle 2 of a divide, plus mthi A=0x5 while Busy -> both ignored: the divide result commits on schedule and HI is not 0x5. Then mthi A=0x5 at Busy=0 -> HI=0x5 one edge later, Busy stays 0.
5. Reset asserted at cycle 3 of a mult -> next edge Busy=0, HI=0, LO=0, and the pending result is never committed.
6. With MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> after 5 cycles HI=0x00000001, LO=0x00000000. Without the macro, the same stimulus leaves Busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mdu.sv
// mdu: MIPS multiply/divide unit with architectural HI/LO registers.
// Ports: Clk, Reset (sync, active-high), Start/Op/A/B request, Busy, HI, LO.
// Optional madd/maddu (Op 110/111) enabled by defining MDU_MADD_EN.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic        wr_q, wr_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, q_mag, r_mag, div_q, div_r;
  logic [31:0] divu_b, divu_q, divu_r;

  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes; a zero divisor is replaced by 1 since
    // that result is discarded anyway. Overflow falls out as 0x80000000 / 0.
    abs_a  = A[31] ? (~A + 32'd1) : A;
    abs_b  = (B == '0) ? 32'd1 : (B[31] ? (~B + 32'd1) : B);
    q_mag  = abs_a / abs_b;
    r_mag  = abs_a % abs_b;
    div_q  = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    div_r  = A[31] ? (~r_mag + 32'd1) : r_mag;

    divu_b = (B == '0) ? 32'd1 : B;
    divu_q = A / divu_b;
    divu_r = A % divu_b;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (Op)
            3'b000: begin
              {hi_n_d, lo_n_d} = prod_s;
              wr_d    = 1'b1;
              cnt_d   = 4'(MULT_CYCLES - 1);
              state_d = RUN;
            end
            3'b001: begin
              {hi_n_d, lo_n_d} = prod_u;
              wr_d    = 1'b1;
              cnt_d   = 4'(MULT_CYCLES - 1);
              state_d = RUN;
            end
            3'b010: begin
              hi_n_d  = div_r;
              lo_n_d  = div_q;
              wr_d    = (B != '0);
              cnt_d   = 4'(DIV_CYCLES - 1);
              state_d = RUN;
            end
            3'b011: begin
              hi_n_d  = divu_r;
              lo_n_d  = divu_q;
              wr_d    = (B != '0);
              cnt_d   = 4'(DIV_CYCLES - 1);
              state_d = RUN;
            end
            3'b100: hi_d = A;
            3'b101: lo_d = A;
`ifdef MDU_MADD_EN
            3'b110: begin
              {hi_n_d, lo_n_d} = {hi_q, lo_q} + prod_s;
              wr_d    = 1'b1;
              cnt_d   = 4'(MULT_CYCLES - 1);
              state_d = RUN;
            end
            3'b111: begin
              {hi_n_d, lo_n_d} = {hi_q, lo_q} + prod_u;
              wr_d    = 1'b1;
              cnt_d   = 4'(MULT_CYCLES - 1);
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          if (wr_q) begin
            hi_d = hi_n_q;
            lo_d = lo_n_q;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
      wr_q    <= wr_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural reference: returns busy length and the HI/LO after the op.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] nh, output logic [31:0] nl);
    longint          ps;
    longint unsigned pu;
    logic [63:0]     acc;
    int              sq, sr;
    n  = 0;
    nh = ref_hi;
    nl = ref_lo;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = longint'({32'd0, a}) * longint'({32'd0, b});
    case (op)
      3'd0: begin n = MC; {nh, nl} = ps; end
      3'd1: begin n = MC; {nh, nl} = pu; end
      3'd2: begin
        n = DC;
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            nl = 32'h8000_0000; nh = 32'h0;
          end else begin
            sq = int'(a) / int'(b);
            sr = int'(a) % int'(b);
            nl = sq; nh = sr;
          end
        end
      end
      3'd3: begin
        n = DC;
        if (b != 0) begin nl = a / b; nh = a % b; end
      end
      3'd4: nh = a;
      3'd5: nl = a;
`ifdef MDU_MADD_EN
      3'd6: begin n = MC; acc = {ref_hi, ref_lo} + ps; {nh, nl} = acc; end
      3'd7: begin n = MC; acc = {ref_hi, ref_lo} + pu; {nh, nl} = acc; end
`endif
      default: ;
    endcase
  endtask

  // Issue an op, check Busy/HI/LO every cycle while busy, then the result.
  // With noise set, Start is also pulsed with other ops while busy,
  // including on the edge where Busy falls; all of these must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    int n;
    logic [31:0] nh, nl, oh, ol;
    oh = ref_hi;
    ol = ref_lo;
    model(op, a, b, n, nh, nl);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      check("busy_run", {31'd0, Busy}, 32'd1);
      check("hi_hold", HI, oh);
      check("lo_hold", LO, ol);
      @(negedge Clk);
      if (noise) begin
        if (i == 1) begin
          Start = 1'b1; Op = 3'd0; A = $urandom; B = $urandom;
        end else if (i == 2) begin
          Start = 1'b1; Op = 3'd4; A = 32'h5;
        end else if (i == n - 1) begin
          Start = 1'b1; Op = 3'd5; A = 32'hDEAD_BEEF;
        end else begin
          Start = 1'($urandom_range(0, 1)); Op = 3'($urandom_range(0, 7));
          A = $urandom; B = $urandom;
        end
      end
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    check("busy_done", {31'd0, Busy}, 32'd0);
    check("hi_result", HI, nh);
    check("lo_result", LO, nl);
    ref_hi = nh;
    ref_lo = nl;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0);

    run_op(3'd4, 32'h11, 32'h0, 1'b0);
    run_op(3'd5, 32'h22, 32'h0, 1'b0);
    run_op(3'd3, 32'h7, 32'h0, 1'b0);
    run_op(3'd2, 32'h7, 32'h0, 1'b0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'h7, 32'hFFFF_FFFE, 1'b0);

    run_op(3'd2, 32'd100, 32'd7, 1'b1);
    run_op(3'd4, 32'h5, 32'h0, 1'b0);

    // Reset in the middle of a multiply discards the pending result.
    @(negedge Clk);
    Start = 1'b1; Op = 3'd1; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    check("midreset_hi", HI, 32'd0);
    check("midreset_lo", LO, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    ref_hi = '0;
    ref_lo = '0;
    repeat (MC + 2) @(posedge Clk);
    #1;
    check("no_commit_hi", HI, 32'd0);
    check("no_commit_lo", LO, 32'd0);

    run_op(3'd4, 32'h0, 32'h0, 1'b0);
    run_op(3'd5, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run_op(3'd6, 32'h1, 32'h1, 1'b0);
    run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = (k % 7 == 3) ? 32'h8000_0000 : $urandom;
      rb  = (k % 5 == 0) ? 32'h0 : ((k % 6 == 1) ? 32'hFFFF_FFFF : $urandom);
      if (k % 4 == 2) rb = rb >> $urandom_range(0, 31);
      run_op(rop, ra, rb, 1'(k % 3 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
